edp_muldiv_seq: RTL and testbench

- Parametrised iterative multiply/divide sequencer for the EBOX data path, one bit per cycle, using AR/MQ/BR-style working registers.
- Offloads the multi-cycle MUL/DIV step loops from microcode, so EDP only loads operands and collects the results.
- Sits beside edp. Operands come from AR (multiplicand/dividend) and BR (multiplier/divisor). The high result returns to AR and the low result to MQ.
- Generalises the fixed 36-bit datapath in two ways: width is a parameter, and signed/unsigned mode is selectable.

---
 rtl/edp_pkg.sv | 27 ++
 rtl/edp_muldiv_step.sv | 40 ++++
 rtl/edp_muldiv_seq.sv | 172 +++++++++++++++++
 tb/tb_edp_muldiv_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/edp_pkg.sv
// Shared definitions for the EBOX multiply/divide sequencer: op encodings,
// sequencer states and the double-word negate used by the MUL sign fixup.
package edp_pkg;

  localparam logic [1:0] OP_MULS = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIVS = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  // Widest operand the negate helper covers; callers cast to/from their own width.
  localparam int MAX_W = 128;

  typedef logic [2*MAX_W-1:0] wide_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP,
    ST_FIXUP,
    ST_DONE
  } state_t;

  function automatic wide_t negate_double(input wide_t v);
    return ~v + {{(2*MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/edp_muldiv_step.sv
// One iteration of the sequencer: shift-add for MUL, restoring
// shift-subtract for DIV, on the {acc, mq} register pair.
module edp_muldiv_step #(
  parameter int WIDTH = 36
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] br,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // acc stays one bit wider than the word so the MUL carry-out and the DIV
  // trial-subtract sign are both visible.
  always_comb begin
    sum     = acc + (mq[0] ? {1'b0, br} : '0);
    shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
    diff    = shifted - {1'b0, br};
    acc_nxt = '0;
    mq_nxt  = '0;
    if (is_div) begin
      if (diff[WIDTH]) begin
        acc_nxt = shifted;
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = diff;
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nxt = {1'b0, sum[WIDTH:1]};
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/edp_muldiv_seq.sv
// Iterative one-bit-per-cycle multiply/divide sequencer beside EDP.
// Operands arrive from AR/BR; high result goes back to AR, low result to MQ.
module edp_muldiv_seq
  import edp_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             eboxClk,
  input  logic             eboxReset_n,
  input  logic             start,
  input  logic [0:1]       op,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  output logic             busy,
  output logic             done,
  output logic             noDivide,
  output logic [0:WIDTH-1] resHi,
  output logic [0:WIDTH-1] resLo
);

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [2*WIDTH-1:0] dword_t;

  // Internal words are numbered LSB=0; assignments to the EDP-numbered ports
  // preserve numeric value.
  state_t           state;
  logic [1:0]       op_q;
  word_t            a_raw;
  word_t            b_raw;
  word_t            br;
  logic [WIDTH:0]   acc;
  word_t            mq;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             busy_q;
  logic             done_q;
  logic             nodiv_q;
  word_t            res_hi_q;
  word_t            res_lo_q;

  logic             is_div;
  logic             is_signed;
  logic             sa;
  logic             sb;
  word_t            a_mag;
  word_t            b_mag;
  word_t            most_neg;
  logic             abort;
  logic [WIDTH:0]   acc_nxt;
  word_t            mq_nxt;
  word_t            rem_mag;
  dword_t           prod;
  dword_t           prod_fix;
  word_t            quo_fix;
  word_t            rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign most_neg  = {1'b1, {(WIDTH-1){1'b0}}};

  assign sa    = is_signed & a_raw[WIDTH-1];
  assign sb    = is_signed & b_raw[WIDTH-1];
  assign a_mag = sa ? ~a_raw + word_t'(1) : a_raw;
  assign b_mag = sb ? ~b_raw + word_t'(1) : b_raw;

  // Quotient of most-negative by -1 does not fit, so it aborts like x/0.
  assign abort = is_div & ((b_raw == '0) |
                           (is_signed & (a_raw == most_neg) & (b_raw == '1)));

  edp_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .mq      (mq),
    .br      (br),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  assign rem_mag  = acc[WIDTH-1:0];
  assign prod     = {rem_mag, mq};
  assign prod_fix = sign_q ? dword_t'(negate_double(wide_t'(prod))) : prod;
  assign quo_fix  = sign_q ? ~mq + word_t'(1) : mq;
  assign rem_fix  = sign_r ? ~rem_mag + word_t'(1) : rem_mag;

  // Sequencer FSM with registered outputs; an abort still passes through
  // FIXUP (without writing results) so done lands two edges after start.
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULS;
      a_raw    <= '0;
      b_raw    <= '0;
      br       <= '0;
      acc      <= '0;
      mq       <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nodiv_q  <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_raw   <= opA;
            b_raw   <= opB;
            nodiv_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          sign_q <= sa ^ sb;
          sign_r <= sa;
          if (abort) begin
            nodiv_q <= 1'b1;
            state   <= ST_FIXUP;
          end else begin
            acc   <= '0;
            mq    <= is_div ? a_mag : b_mag;
            br    <= is_div ? b_mag : a_mag;
            cnt   <= CNT_W'(WIDTH);
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          acc <= acc_nxt;
          mq  <= mq_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          if (!nodiv_q) begin
            if (is_div) begin
              res_hi_q <= rem_fix;
              res_lo_q <= quo_fix;
            end else begin
              res_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              res_lo_q <= prod_fix[WIDTH-1:0];
            end
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign noDivide = nodiv_q;
  assign resHi    = res_hi_q;
  assign resLo    = res_lo_q;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Directed self-checking bench for edp_muldiv_seq at WIDTH=36 and WIDTH=8.
module tb_edp_muldiv_seq;

  logic eboxClk = 1'b0;
  always #5 eboxClk = ~eboxClk;

  logic eboxReset_n;

  logic        start36;
  logic [0:1]  op36;
  logic [0:35] opA36;
  logic [0:35] opB36;
  logic        busy36;
  logic        done36;
  logic        nd36;
  logic [0:35] hi36;
  logic [0:35] lo36;

  logic        start8;
  logic [0:1]  op8;
  logic [0:7]  opA8;
  logic [0:7]  opB8;
  logic        busy8;
  logic        done8;
  logic        nd8;
  logic [0:7]  hi8;
  logic [0:7]  lo8;

  int errors = 0;
  int checks = 0;

  edp_muldiv_seq #(.WIDTH(36)) dut36 (
    .eboxClk     (eboxClk),
    .eboxReset_n (eboxReset_n),
    .start       (start36),
    .op          (op36),
    .opA         (opA36),
    .opB         (opB36),
    .busy        (busy36),
    .done        (done36),
    .noDivide    (nd36),
    .resHi       (hi36),
    .resLo       (lo36)
  );

  edp_muldiv_seq #(.WIDTH(8)) dut8 (
    .eboxClk     (eboxClk),
    .eboxReset_n (eboxReset_n),
    .start       (start8),
    .op          (op8),
    .opA         (opA8),
    .opB         (opB8),
    .busy        (busy8),
    .done        (done8),
    .noDivide    (nd8),
    .resHi       (hi8),
    .resLo       (lo8)
  );

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one WIDTH=36 operation and check latency, flags and results.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [35:0] a,
                               input logic [35:0] b, input int expLat, input logic [35:0] expHi,
                               input logic [35:0] expLo, input logic expNd);
    int lat;
    @(negedge eboxClk);
    start36 = 1'b1;
    op36    = op;
    opA36   = a;
    opB36   = b;
    @(posedge eboxClk);
    #1 start36 = 1'b0;
    checkOutput({tag, "_busy"}, busy36, 1);
    checkOutput({tag, "_ndclr"}, nd36, 0);
    lat = 0;
    while (!done36 && lat < 100) begin
      @(posedge eboxClk);
      #1 lat++;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_nd"}, nd36, expNd);
    checkOutput({tag, "_hi"}, hi36, expHi);
    checkOutput({tag, "_lo"}, lo36, expLo);
    checkOutput({tag, "_busy0"}, busy36, 0);
    @(posedge eboxClk);
    #1 checkOutput({tag, "_pulse"}, done36, 0);
  endtask

  initial begin
    int lat;
    int doneCount;
    eboxReset_n = 1'b0;
    start36 = 1'b0; op36 = 2'b00; opA36 = '0; opB36 = '0;
    start8  = 1'b0; op8  = 2'b00; opA8  = '0; opB8  = '0;
    #12;
    checkOutput("rst_busy", busy36, 0);
    checkOutput("rst_done", done36, 0);
    checkOutput("rst_nd", nd36, 0);
    checkOutput("rst_hi", hi36, 0);
    checkOutput("rst_lo", lo36, 0);
    @(negedge eboxClk);
    eboxReset_n = 1'b1;

    applyStimulus("mulu_3x5", 2'b01, 36'd3, 36'd5, 38, 36'h0, 36'h00000000F, 1'b0);
    applyStimulus("mulu_max", 2'b01, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 38,
                  36'hFFFFFFFFE, 36'h000000001, 1'b0);
    applyStimulus("muls_m1m1", 2'b00, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 38, 36'h0, 36'h1, 1'b0);
    applyStimulus("muls_negsq", 2'b00, 36'h800000000, 36'h800000000, 38,
                  36'h400000000, 36'h0, 1'b0);
    applyStimulus("divs_m7d2", 2'b10, 36'hFFFFFFFF9, 36'd2, 38,
                  36'hFFFFFFFFF, 36'hFFFFFFFFD, 1'b0);
    applyStimulus("divu_zero", 2'b11, 36'd12345, 36'd0, 2,
                  36'hFFFFFFFFF, 36'hFFFFFFFFD, 1'b1);
    applyStimulus("divs_ovf", 2'b10, 36'h800000000, 36'hFFFFFFFFF, 2,
                  36'hFFFFFFFFF, 36'hFFFFFFFFD, 1'b1);
    applyStimulus("divs_7dm2", 2'b10, 36'd7, 36'hFFFFFFFFE, 38,
                  36'h000000001, 36'hFFFFFFFFD, 1'b0);

    // Async reset in the middle of a multiply clears everything at once.
    @(negedge eboxClk);
    start36 = 1'b1; op36 = 2'b01; opA36 = 36'd3; opB36 = 36'd5;
    @(posedge eboxClk);
    #1 start36 = 1'b0;
    repeat (5) @(posedge eboxClk);
    #2 eboxReset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy36, 0);
    checkOutput("midrst_done", done36, 0);
    checkOutput("midrst_nd", nd36, 0);
    checkOutput("midrst_hi", hi36, 0);
    checkOutput("midrst_lo", lo36, 0);
    @(negedge eboxClk);
    eboxReset_n = 1'b1;

    // A start held during busy must not queue a second operation.
    @(negedge eboxClk);
    start36 = 1'b1; op36 = 2'b01; opA36 = 36'd7; opB36 = 36'd9;
    @(posedge eboxClk);
    #1 start36 = 1'b0;
    @(negedge eboxClk);
    start36 = 1'b1; opA36 = 36'd2; opB36 = 36'd2;
    repeat (3) @(negedge eboxClk);
    start36 = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge eboxClk);
      #1 if (done36) doneCount++;
    end
    checkOutput("busystart_pulses", doneCount, 1);
    checkOutput("busystart_hi", hi36, 0);
    checkOutput("busystart_lo", lo36, 36'h3F);

    // WIDTH=8 unsigned divide.
    @(negedge eboxClk);
    start8 = 1'b1; op8 = 2'b11; opA8 = 8'd200; opB8 = 8'd7;
    @(posedge eboxClk);
    #1 start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge eboxClk);
      #1 lat++;
    end
    checkOutput("w8_lat", lat, 10);
    checkOutput("w8_lo", lo8, 8'd28);
    checkOutput("w8_hi", hi8, 8'd4);
    checkOutput("w8_nd", nd8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
